// File: rtl/bowling_pkg.sv
// ---------------------------------------------------------------------------
// bowling_pkg
//   Shared definitions for the bowling game blocks:
//     state_e      encoded throw/game FSM state (IDLE=0 .. GAME_OVER=6)
//     ARROW_*      aim-arrow position range and centre
//     PINS_MAX     pins in a full rack
//     sat_pins()   clamp a reported pin count to PINS_MAX
// ---------------------------------------------------------------------------
package bowling_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_AIM       = 3'd1,
    ST_POWER     = 3'd2,
    ST_LAUNCH    = 3'd3,
    ST_ROLLING   = 3'd4,
    ST_SCORE     = 3'd5,
    ST_GAME_OVER = 3'd6
  } state_e;

  localparam logic [3:0] ARROW_MIN    = 4'd1;
  localparam logic [3:0] ARROW_MAX    = 4'd9;
  localparam logic [3:0] ARROW_CENTER = 4'd5;
  localparam logic [3:0] PINS_MAX     = 4'd10;

  // The ball model may report garbage above a full rack; treat it as a strike.
  function automatic logic [3:0] sat_pins(input logic [3:0] p);
    return (p > PINS_MAX) ? PINS_MAX : p;
  endfunction

endpackage

// File: rtl/throw_sequencer_power_meter.sv
// ---------------------------------------------------------------------------
// power_meter
//   Ping-pong counter 1..PWR_MAX used as the throw power gauge.
//   Ports:
//     clk, reset  clock, synchronous active-high reset (power -> 1, rising)
//     load        restart at 1, counting up (has priority over everything)
//     en          advance one step (one tick)
//     freeze      suppress the step this cycle (confirm wins over tick)
//     power       current gauge value
//   The direction flips on the step that leaves an endpoint, so neither
//   endpoint is ever shown for two consecutive steps. PWR_MAX must be >= 2
//   for the gauge to move; with PWR_MAX == 1 it simply stays at 1.
// ---------------------------------------------------------------------------
module power_meter #(
  parameter int PWR_MAX = 9
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic       en,
  input  logic       freeze,
  output logic [3:0] power
);

  localparam logic [3:0] MAX_L = 4'(PWR_MAX);

  logic [3:0] power_q, power_d;
  logic       up_q, up_d;

  always_comb begin
    power_d = power_q;
    up_d    = up_q;
    if (load) begin
      power_d = 4'd1;
      up_d    = 1'b1;
    end else if (en && !freeze && (MAX_L > 4'd1)) begin
      if (up_q) begin
        if (power_q >= MAX_L) begin
          power_d = power_q - 4'd1;
          up_d    = 1'b0;
        end else begin
          power_d = power_q + 4'd1;
        end
      end else begin
        if (power_q <= 4'd1) begin
          power_d = power_q + 4'd1;
          up_d    = 1'b1;
        end else begin
          power_d = power_q - 4'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      power_q <= 4'd1;
      up_q    <= 1'b1;
    end else begin
      power_q <= power_d;
      up_q    <= up_d;
    end
  end

  assign power = power_q;

endmodule

// File: rtl/throw_sequencer.sv
// ---------------------------------------------------------------------------
// throw_sequencer
//   Controller for one bowling throw plus the frame/roll bookkeeping of a
//   game. Gates aim requests to the arrow FSM, runs the power gauge, issues
//   the launch strobe, waits for the ball model and scores the roll.
//
//   Handshake: all request inputs (btn_*, tick, ball_done) are single-cycle
//   pulses sampled on the rising clk edge; there is no back-pressure. A
//   pulse arriving in a state that does not consume it is dropped.
//
//   Ports:
//     clk, reset        clock, synchronous active-high reset (-> IDLE)
//     tick              slow enable pulse (power gauge, roll timeout, sweep)
//     btn_left/right    aim requests; btn_confirm advances IDLE/AIM/POWER/
//                       GAME_OVER
//     x_pos             arrow position from the arrow FSM (1..9)
//     ball_done         roll finished; pins_down valid with it
//     arrow_left/right  combinational strobes to the arrow FSM (AIM only)
//     aim_pos, power    latched aim, live/latched power
//     launch            registered, high while state == LAUNCH
//     frame, roll       game progress (frame 1..NUM_FRAMES, roll 0/1)
//     game_over         high in GAME_OVER
//     state             encoded FSM state for display/debug
//
//   Build option AUTO_SWEEP_EN: when defined, the block sweeps the arrow
//   itself (one strobe per tick, bouncing between ARROW_MIN and ARROW_MAX)
//   and ignores btn_left/btn_right. Otherwise aiming is manual.
// ---------------------------------------------------------------------------
module throw_sequencer
  import bowling_pkg::*;
#(
  parameter int NUM_FRAMES   = 10,
  parameter int PWR_MAX      = 9,
  parameter int ROLL_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_confirm,
  input  logic [3:0] x_pos,
  input  logic       ball_done,
  input  logic [3:0] pins_down,
  output logic       arrow_left,
  output logic       arrow_right,
  output logic [3:0] aim_pos,
  output logic [3:0] power,
  output logic       launch,
  output logic [3:0] frame,
  output logic       roll,
  output logic       game_over,
  output logic [2:0] state
);

  localparam int         CNT_W     = $clog2(ROLL_TIMEOUT + 1);
  localparam logic [3:0] LAST_FRM  = 4'(NUM_FRAMES);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(ROLL_TIMEOUT - 1);

  state_e           state_q, state_d;
  logic [3:0]       aim_q, aim_d;
  logic [3:0]       frame_q, frame_d;
  logic             roll_q, roll_d;
  logic [3:0]       pins_q, pins_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             launch_q, launch_d;
  logic             game_over_q, game_over_d;
  logic             meter_load;
  logic             meter_en;

  // -------------------------------------------------------------------------
  // Next-state and datapath
  // -------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    aim_d      = aim_q;
    frame_d    = frame_q;
    roll_d     = roll_q;
    pins_d     = pins_q;
    cnt_d      = cnt_q;
    meter_load = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (btn_confirm) state_d = ST_AIM;
      end

      ST_AIM: begin
        // x_pos still reflects the position before any same-cycle strobe.
        if (btn_confirm) begin
          aim_d      = x_pos;
          meter_load = 1'b1;
          state_d    = ST_POWER;
        end
      end

      ST_POWER: begin
        if (btn_confirm) state_d = ST_LAUNCH;
      end

      ST_LAUNCH: begin
        cnt_d   = '0;
        state_d = ST_ROLLING;
      end

      ST_ROLLING: begin
        if (tick) cnt_d = cnt_q + 1'b1;
        // ball_done takes priority over a timeout landing in the same cycle.
        if (ball_done) begin
          pins_d  = sat_pins(pins_down);
          state_d = ST_SCORE;
        end else if (tick && (cnt_q == TO_LAST)) begin
          pins_d  = 4'd0;
          state_d = ST_SCORE;
        end
      end

      ST_SCORE: begin
        if (!roll_q && (pins_q != PINS_MAX)) begin
          roll_d  = 1'b1;
          state_d = ST_AIM;
        end else begin
          roll_d = 1'b0;
          if (frame_q == LAST_FRM) begin
            state_d = ST_GAME_OVER;
          end else begin
            frame_d = frame_q + 4'd1;
            state_d = ST_AIM;
          end
        end
      end

      ST_GAME_OVER: begin
        if (btn_confirm) begin
          frame_d = 4'd1;
          roll_d  = 1'b0;
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    // Registered outputs follow the state being entered.
    launch_d    = (state_d == ST_LAUNCH);
    game_over_d = (state_d == ST_GAME_OVER);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      aim_q       <= ARROW_CENTER;
      frame_q     <= 4'd1;
      roll_q      <= 1'b0;
      pins_q      <= 4'd0;
      cnt_q       <= '0;
      launch_q    <= 1'b0;
      game_over_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      aim_q       <= aim_d;
      frame_q     <= frame_d;
      roll_q      <= roll_d;
      pins_q      <= pins_d;
      cnt_q       <= cnt_d;
      launch_q    <= launch_d;
      game_over_q <= game_over_d;
    end
  end

  // -------------------------------------------------------------------------
  // Power gauge: restarts on entry to POWER, steps on tick while in POWER,
  // and a confirm in POWER holds the pre-tick value. Outside POWER it holds.
  // -------------------------------------------------------------------------
  assign meter_en = tick && (state_q == ST_POWER);

  power_meter #(
    .PWR_MAX (PWR_MAX)
  ) u_power_meter (
    .clk    (clk),
    .reset  (reset),
    .load   (meter_load),
    .en     (meter_en),
    .freeze (btn_confirm),
    .power  (power)
  );

  // -------------------------------------------------------------------------
  // Arrow strobes
  // -------------------------------------------------------------------------
`ifdef AUTO_SWEEP_EN
  logic sweep_right_q, sweep_right_d;
  logic sweep_go_right;
  logic unused_btns;

  assign unused_btns = btn_left ^ btn_right;

  always_comb begin
    // Bounce off the end the arrow has reached before choosing the strobe.
    sweep_go_right = sweep_right_q;
    if (sweep_right_q && (x_pos >= ARROW_MAX)) begin
      sweep_go_right = 1'b0;
    end else if (!sweep_right_q && (x_pos <= ARROW_MIN)) begin
      sweep_go_right = 1'b1;
    end

    sweep_right_d = sweep_right_q;
    arrow_left    = 1'b0;
    arrow_right   = 1'b0;
    if ((state_q == ST_AIM) && tick) begin
      arrow_right   = sweep_go_right;
      arrow_left    = !sweep_go_right;
      sweep_right_d = sweep_go_right;
    end
    if ((state_d == ST_AIM) && (state_q != ST_AIM)) sweep_right_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) sweep_right_q <= 1'b1;
    else       sweep_right_q <= sweep_right_d;
  end
`else
  always_comb begin
    arrow_left  = 1'b0;
    arrow_right = 1'b0;
    if (state_q == ST_AIM) begin
      // Left wins when both requests arrive together.
      arrow_left  = btn_left;
      arrow_right = btn_right && !btn_left;
    end
  end
`endif

  assign aim_pos   = aim_q;
  assign launch    = launch_q;
  assign frame     = frame_q;
  assign roll      = roll_q;
  assign game_over = game_over_q;
  assign state     = state_q;

endmodule

// File: tb/tb_throw_sequencer.sv
// ---------------------------------------------------------------------------
// tb_throw_sequencer
//   Table of single-cycle vectors for one full frame, then hand-written
//   sequences for the power gauge, timeout, strike priority, a full game of
//   strikes, and reset in the middle of a throw.
// ---------------------------------------------------------------------------
module tb_throw_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       tick, btn_left, btn_right, btn_confirm, ball_done;
  logic [3:0] x_pos, pins_down;
  logic       arrow_left, arrow_right, launch, roll, game_over;
  logic [3:0] aim_pos, power, frame;
  logic [2:0] state;

  int n_pass  = 0;
  int n_total = 0;

  logic [6:0] exp_q[$];

  throw_sequencer dut (
    .clk         (clk),
    .reset       (reset),
    .tick        (tick),
    .btn_left    (btn_left),
    .btn_right   (btn_right),
    .btn_confirm (btn_confirm),
    .x_pos       (x_pos),
    .ball_done   (ball_done),
    .pins_down   (pins_down),
    .arrow_left  (arrow_left),
    .arrow_right (arrow_right),
    .aim_pos     (aim_pos),
    .power       (power),
    .launch      (launch),
    .frame       (frame),
    .roll        (roll),
    .game_over   (game_over),
    .state       (state)
  );

  // -------------------------------------------------------------------------
  // Clock / reset
  // -------------------------------------------------------------------------
  always #5 clk = ~clk;

  // -------------------------------------------------------------------------
  // Driver tasks
  // -------------------------------------------------------------------------
  task automatic clr_inputs();
    tick        = 1'b0;
    btn_left    = 1'b0;
    btn_right   = 1'b0;
    btn_confirm = 1'b0;
    ball_done   = 1'b0;
    pins_down   = 4'd0;
  endtask

  // Advance past the next rising edge; inputs set afterwards are stable
  // well before the following edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_confirm();
    btn_confirm = 1'b1;
    step();
    btn_confirm = 1'b0;
  endtask

  // AIM -> POWER -> LAUNCH -> ROLLING
  task automatic go_roll(input logic [3:0] x);
    x_pos = x;
    pulse_confirm();
    pulse_confirm();
    step();
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) begin
      tick = 1'b1;
      step();
      tick = 1'b0;
      step();
    end
  endtask

  task automatic chk(input string name, input int act, input int exp_v);
    n_total++;
    if (act == exp_v) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp_v);
  endtask

  // Triangle wave over 1..9: value after k ticks from entry.
  function automatic int tri_power(input int k);
    int period;
    int m;
    period = 2 * (9 - 1);
    m = k % period;
    return (m < 8) ? (1 + m) : (1 + period - m);
  endfunction

  // -------------------------------------------------------------------------
  // Vector table
  // -------------------------------------------------------------------------
  typedef struct {
    logic       tk, bl, br, bc;
    logic [3:0] x;
    logic       bd;
    logic [3:0] pins;
    logic       al, ar;
    int         st, fr, rl, ln, aim, pw;
  } vec_t;

  vec_t vt[16];

  function automatic vec_t mk(input logic tk, bl, br, bc, input logic [3:0] x,
                              input logic bd, input logic [3:0] pins,
                              input logic al, ar,
                              input int st, fr, rl, ln, aim, pw);
    vec_t v;
    v.tk = tk; v.bl = bl; v.br = br; v.bc = bc; v.x = x; v.bd = bd;
    v.pins = pins; v.al = al; v.ar = ar; v.st = st; v.fr = fr; v.rl = rl;
    v.ln = ln; v.aim = aim; v.pw = pw;
    return v;
  endfunction

  initial begin
    int exp_al, exp_ar;
    logic [6:0] got, want;

    //          tk bl br bc x   bd pins al ar st fr rl ln aim pw
    vt[0]  = mk(1, 0, 1, 0, 5, 0, 0,  0, 0, 0, 1, 0, 0, 5, 1); // right in IDLE
    vt[1]  = mk(0, 0, 0, 1, 5, 0, 0,  0, 0, 1, 1, 0, 0, 5, 1); // IDLE -> AIM
    vt[2]  = mk(0, 0, 1, 0, 5, 0, 0,  0, 1, 1, 1, 0, 0, 5, 1); // right strobe
    vt[3]  = mk(0, 1, 1, 0, 5, 0, 0,  1, 0, 1, 1, 0, 0, 5, 1); // both: left only
    vt[4]  = mk(0, 1, 0, 1, 4, 0, 0,  1, 0, 2, 1, 0, 0, 4, 1); // move + confirm
    vt[5]  = mk(0, 0, 0, 0, 6, 1, 7,  0, 0, 2, 1, 0, 0, 4, 1); // stray ball_done
    vt[6]  = mk(0, 0, 0, 1, 6, 0, 0,  0, 0, 3, 1, 0, 1, 4, 1); // POWER -> LAUNCH
    vt[7]  = mk(0, 0, 0, 0, 6, 0, 0,  0, 0, 4, 1, 0, 0, 4, 1); // -> ROLLING
    vt[8]  = mk(0, 0, 0, 0, 6, 1, 3,  0, 0, 5, 1, 0, 0, 4, 1); // 3 pins
    vt[9]  = mk(0, 0, 0, 0, 6, 0, 0,  0, 0, 1, 1, 1, 0, 4, 1); // second ball
    vt[10] = mk(0, 0, 0, 1, 7, 0, 0,  0, 0, 2, 1, 1, 0, 7, 1);
    vt[11] = mk(1, 0, 0, 0, 7, 0, 0,  0, 0, 2, 1, 1, 0, 7, 2);
    vt[12] = mk(0, 0, 0, 1, 7, 0, 0,  0, 0, 3, 1, 1, 1, 7, 2);
    vt[13] = mk(1, 0, 0, 0, 7, 0, 0,  0, 0, 4, 1, 1, 0, 7, 2); // tick in LAUNCH
    vt[14] = mk(0, 0, 0, 0, 7, 1, 4,  0, 0, 5, 1, 1, 0, 7, 2); // 4 pins
    vt[15] = mk(0, 0, 0, 0, 7, 0, 0,  0, 0, 1, 2, 0, 0, 7, 2); // frame 2

    clr_inputs();
    x_pos = 4'd5;
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;

    // Reset values
    chk("rst_state", state, 0);
    chk("rst_frame", frame, 1);
    chk("rst_roll", roll, 0);
    chk("rst_aim", aim_pos, 5);
    chk("rst_power", power, 1);
    chk("rst_launch", launch, 0);
    chk("rst_game_over", game_over, 0);

    // Table vectors
    for (int i = 0; i < 16; i++) begin
      tick = vt[i].tk; btn_left = vt[i].bl; btn_right = vt[i].br;
      btn_confirm = vt[i].bc; x_pos = vt[i].x; ball_done = vt[i].bd;
      pins_down = vt[i].pins;
      exp_al = vt[i].al;
      exp_ar = vt[i].ar;
`ifdef AUTO_SWEEP_EN
      // Buttons are ignored and no AIM row carries a tick.
      exp_al = 0;
      exp_ar = 0;
`endif
      #1;
      chk($sformatf("v%0d_arrow_left", i), arrow_left, exp_al);
      chk($sformatf("v%0d_arrow_right", i), arrow_right, exp_ar);
      step();
      clr_inputs();
      chk($sformatf("v%0d_state", i), state, vt[i].st);
      chk($sformatf("v%0d_frame", i), frame, vt[i].fr);
      chk($sformatf("v%0d_roll", i), roll, vt[i].rl);
      chk($sformatf("v%0d_launch", i), launch, vt[i].ln);
      chk($sformatf("v%0d_aim", i), aim_pos, vt[i].aim);
      chk($sformatf("v%0d_power", i), power, vt[i].pw);
    end

    // Power gauge: 11 ticks, then tick together with confirm
    x_pos = 4'd3;
    pulse_confirm();
    chk("pw_entry_state", state, 2);
    chk("pw_entry_value", power, 1);
    for (int k = 1; k <= 11; k++) begin
      tick = 1'b1;
      exp_q.push_back(7'(tri_power(k)));
      step();
      tick = 1'b0;
      got  = 7'(power);
      want = exp_q.pop_front();
      chk($sformatf("pw_tick%0d", k), got, want);
      if (k % 3 == 0) step(); // idle cycles between ticks must not move it
    end
    tick = 1'b1;
    btn_confirm = 1'b1;
    step();
    clr_inputs();
    chk("pw_hold_value", power, 6);
    chk("pw_launch_state", state, 3);
    chk("pw_launch_hi", launch, 1);
    chk("pw_aim", aim_pos, 3);
    step();
    chk("pw_launch_lo", launch, 0);
    chk("pw_hold_after", power, 6);

    // Oversized pin count saturates to a strike
    ball_done = 1'b1; pins_down = 4'd12;
    step();
    clr_inputs();
    chk("sat_score_state", state, 5);
    step();
    chk("sat_frame", frame, 3);
    chk("sat_roll", roll, 0);
    chk("sat_state", state, 1);

    // Timeout on the first ball of frame 3
    go_roll(4'd5);
    tick_n(14);
    chk("to_still_rolling", state, 4);
    tick = 1'b1;
    step();
    tick = 1'b0;
    chk("to_score", state, 5);
    step();
    chk("to_roll", roll, 1);
    chk("to_frame", frame, 3);
    chk("to_state", state, 1);

    go_roll(4'd5);
    ball_done = 1'b1; pins_down = 4'd5;
    step();
    clr_inputs();
    step();
    chk("f3_frame", frame, 4);
    chk("f3_roll", roll, 0);

    // ball_done beats a coincident timeout: a strike ends the frame
    go_roll(4'd5);
    tick_n(14);
    tick = 1'b1; ball_done = 1'b1; pins_down = 4'd10;
    step();
    clr_inputs();
    chk("prio_score", state, 5);
    step();
    chk("prio_frame", frame, 5);
    chk("prio_roll", roll, 0);

    // Full game of strikes
    reset = 1'b1;
    step();
    reset = 1'b0;
    pulse_confirm();
    for (int f = 0; f < 10; f++) begin
      go_roll(4'(1 + f % 9));
      ball_done = 1'b1; pins_down = 4'd10;
      step();
      clr_inputs();
      step();
      exp_q.push_back((f < 9) ? {3'd1, 4'(f + 2)} : {3'd6, 4'd10});
      got  = {state, frame};
      want = exp_q.pop_front();
      chk($sformatf("strike%0d_state_frame", f + 1), got, want);
    end
    chk("go_flag", game_over, 1);
    chk("go_roll", roll, 0);
    tick = 1'b1; ball_done = 1'b1;
    step();
    clr_inputs();
    chk("go_ignores_inputs", state, 6);
    pulse_confirm();
    chk("go_to_idle", state, 0);
    chk("go_frame", frame, 1);
    chk("go_roll_cleared", roll, 0);
    chk("go_flag_cleared", game_over, 0);

    // Reset while rolling
    pulse_confirm();
    x_pos = 4'd2;
    pulse_confirm();
    tick_n(1);
    pulse_confirm();
    step();
    chk("mr_pre_state", state, 4);
    chk("mr_pre_power", power, 2);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("mr_state", state, 0);
    chk("mr_launch", launch, 0);
    chk("mr_aim", aim_pos, 5);
    chk("mr_power", power, 1);
    chk("mr_frame", frame, 1);

    // Reset together with the power confirm: no launch
    pulse_confirm();
    pulse_confirm();
    btn_confirm = 1'b1; reset = 1'b1;
    step();
    btn_confirm = 1'b0; reset = 1'b0;
    chk("rl_state", state, 0);
    chk("rl_launch", launch, 0);
    step();
    chk("rl_launch_after", launch, 0);

`ifdef AUTO_SWEEP_EN
    // Auto sweep: right to 9, then back left, buttons ignored
    pulse_confirm();
    tick = 1'b1; x_pos = 4'd8;
    #1;
    chk("sw_x8_right", arrow_right, 1);
    chk("sw_x8_left", arrow_left, 0);
    step();
    x_pos = 4'd9;
    #1;
    chk("sw_x9_left", arrow_left, 1);
    chk("sw_x9_right", arrow_right, 0);
    step();
    tick = 1'b0; x_pos = 4'd8; btn_right = 1'b1;
    #1;
    chk("sw_btn_ignored", arrow_right, 0);
    step();
    btn_right = 1'b0; tick = 1'b1;
    #1;
    chk("sw_x8_still_left", arrow_left, 1);
    step();
    x_pos = 4'd1;
    #1;
    chk("sw_x1_right", arrow_right, 1);
    step();
    clr_inputs();
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/throw_sequencer.md
Name: throw_sequencer

Overview:
- Top-level controller for one bowling throw and the game frame count.
- Gates player left/right requests into the aim-arrow FSM while aiming, then runs an oscillating power meter, issues a one-cycle launch strobe, and waits for the ball model to finish.
- Tracks roll and frame number across a game; sits between the input/debounce logic and the arrow, ball and display blocks.

Parameters:
- NUM_FRAMES, 10, frames per game.
- PWR_MAX, 9, top power level; meter range is 1..PWR_MAX.
- ROLL_TIMEOUT, 15, ticks allowed in ROLLING before a forced end of roll.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high; returns the block to IDLE
- tick  in  1  one-cycle enable pulse, nominally every 0.5 s
- btn_left  in  1  one-cycle left request (debounced)
- btn_right  in  1  one-cycle right request (debounced)
- btn_confirm  in  1  one-cycle confirm/start request
- x_pos  in  4  current arrow position, 1..9, from the arrow FSM
- ball_done  in  1  one-cycle pulse from the ball model: roll finished
- pins_down  in  4  pins knocked this roll, 0..10; valid when ball_done is high
- arrow_left  out  1  left strobe to the arrow FSM
- arrow_right  out  1  right strobe to the arrow FSM
- aim_pos  out  4  aim position latched at aim confirm
- power  out  4  live meter value, or the latched value after power confirm
- launch  out  1  one-cycle launch strobe
- frame  out  4  current frame, 1..NUM_FRAMES
- roll  out  1  0 = first ball, 1 = second ball
- game_over  out  1  high in GAME_OVER
- state  out  3  encoded FSM state, for display and debug

Behaviour:
- Reset values:
  - state = IDLE; frame = 1; roll = 0.
  - aim_pos = 5; power = 1.
  - launch, arrow_left, arrow_right and game_over = 0.
- States and transitions:
  - IDLE: confirm -> AIM.
  - AIM: confirm -> POWER.
  - POWER: confirm -> LAUNCH.
  - LAUNCH: unconditional -> ROLLING.
  - ROLLING: ball_done or timeout -> SCORE.
  - SCORE: unconditional -> AIM, or -> GAME_OVER.
  - GAME_OVER: confirm -> IDLE, with frame = 1 and roll = 0.
- AIM:
  - arrow_left = btn_left and arrow_right = btn_right, combinational, same cycle.
  - If both are high, only arrow_left is asserted.
  - In every other state, both strobes are 0.
  - On confirm, aim_pos <= x_pos.
  - A button request and confirm in the same cycle: the strobe still passes, and aim_pos captures the pre-move x_pos.
- POWER:
  - power is set to 1 on entry.
  - On each tick, power ping-pongs: 1,2,...,PWR_MAX,PWR_MAX-1,...,1,2,...
  - Direction flips at each endpoint; an endpoint is never held for 2 ticks.
  - On confirm, power freezes at its current value. If tick and confirm arrive together, the pre-tick value is held.
- LAUNCH:
  - launch = 1 for exactly one cycle, registered: it is high in the cycle in which state == LAUNCH.
- ROLLING:
  - A tick counter resets on entry.
  - Timeout occurs when the count reaches ROLL_TIMEOUT; the roll is then scored as pins_down = 0.
  - ball_done wins over a timeout in the same cycle.
- SCORE (one cycle), using pins latched on ball_done:
  - roll 0 and pins = 10 (strike): end of frame.
  - roll 0 and pins < 10: roll <= 1, -> AIM.
  - roll 1: end of frame.
  - End of frame: roll <= 0. If frame == NUM_FRAMES -> GAME_OVER; else frame <= frame+1, -> AIM.
- pins_down values above 10 saturate to 10.
- There are no bonus balls in the last frame.
- aim_pos and power hold their values until the next capture.
- ball_done outside ROLLING is ignored.
- tick affects only POWER and ROLLING.
- Reset mid-throw: IDLE on the next clk edge, with all outputs at their reset values. No launch is issued.

Optional Feature:
- Macro: AUTO_SWEEP_EN.
- Defined:
  - In AIM, btn_left and btn_right are ignored.
  - The block drives the arrow itself with one strobe per tick: right strobes until x_pos == 9, then left strobes until x_pos == 1, repeating.
  - The sweep direction resets to right on entry to AIM.
  - Confirm latches x_pos as usual.
- Undefined: manual aiming as described above.

Decomposition:
- Shared package bowling_pkg holds:
  - state encodings: IDLE=0, AIM=1, POWER=2, LAUNCH=3, ROLLING=4, SCORE=5, GAME_OVER=6;
  - ARROW_MIN=1, ARROW_MAX=9, ARROW_CENTER=5, PINS_MAX=10.
- One natural sub-module, power_meter: ping-pong counter with enable, load and freeze, parameterised by PWR_MAX.

Test Plan:
- Reset, then confirm: state goes 0->1; aim_pos=5, frame=1, roll=0. btn_right in AIM gives arrow_right=1 that cycle; btn_right in IDLE gives arrow_right=0.
- In POWER, 12 ticks: power sequence is 1,2,3,4,5,6,7,8,9,8,7,6,5. Confirm together with the 12th tick holds power=6 and gives one launch pulse.
- First roll, ball_done with pins_down=10: SCORE leads to frame=2, roll=0, state=AIM.
- First roll with pins=3, then second roll with pins=4: after the first, roll=1 and frame=1; after the second, frame=2 and roll=0.
- No ball_done for 15 ticks in ROLLING: forced SCORE with pins 0, then roll=1. Ten consecutive strikes give game_over=1; confirm then gives IDLE with frame=1.
- Reset asserted in ROLLING gives IDLE next cycle with launch=0. With AUTO_SWEEP_EN, x_pos 8 -> 9 produces right strobes, then left strobes back from 9.
